s2p_packer: RTL and testbench
=============================

S2P_PACKER -- requirements
Module: s2p_packer

Interface
REQ-001 Parameter DATA_WIDTH, default 9, SHALL set the signed width of every I and Q sample.
REQ-002 Parameter OUT_SIZE, default 16, SHALL set the number of parallel output lanes and SHALL be a power of two, 2 or larger.
REQ-003 Parameter NUM_BLK, default 32, SHALL set the number of output blocks per frame and SHALL be 1 or larger.
REQ-004 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-005 rstn  input  1  SHALL be an asynchronous, active-low reset.
REQ-006 din_valid  input  1  SHALL mark din_i/din_q as one valid serial sample in the current cycle.
REQ-007 din_i, din_q  input  signed DATA_WIDTH each  SHALL carry the serial I and Q sample.
REQ-008 flush  input  1  SHALL be a synchronous abort that discards any partial block and partial frame.
REQ-009 dout_i, dout_q  output  signed DATA_WIDTH x [0:OUT_SIZE-1]  SHALL carry the registered parallel block, lane 0 first.
REQ-010 dout_valid  output  1  SHALL pulse for one cycle per completed block; it feeds the downstream parallel buffer's din_valid.
REQ-011 frame_start  output  1  SHALL be high together with dout_valid for block 0 of a frame.
REQ-012 frame_done  output  1  SHALL be high together with dout_valid for block NUM_BLK-1 of a frame.
REQ-013 busy  output  1  SHALL be high while in state FILL.

Function
REQ-014 The FSM SHALL have two states, IDLE and FILL, and SHALL reset to IDLE.
REQ-015 In IDLE, an accepted sample (din_valid=1, flush=0) SHALL be written to lane slot 0 and SHALL move the FSM to FILL with lane_cnt=1.
REQ-016 In FILL, each accepted sample SHALL be written to lane slot lane_cnt, and lane_cnt SHALL then increment.
REQ-017 Cycles with din_valid=0 SHALL hold lane_cnt, blk_cnt, the staging lanes and the state unchanged; gaps of any length are legal.
REQ-018 On the accepted sample with lane_cnt=OUT_SIZE-1:
- the full block, including this sample, SHALL be copied into dout_i/dout_q;
- dout_valid SHALL be 1 in the next cycle only;
- lane_cnt SHALL wrap to 0 and the FSM SHALL return to IDLE.
REQ-019 Latency SHALL be exactly 1 cycle, measured from the clock edge that accepts the last sample of a block to dout_valid=1.
REQ-020 dout_i/dout_q SHALL hold their value between dout_valid pulses and SHALL change only when a block completes.
REQ-021 blk_cnt SHALL increment on each completed block and SHALL wrap from NUM_BLK-1 to 0.
REQ-022 With NUM_BLK=1, frame_start and frame_done SHALL both be high on every dout_valid.
REQ-023 Back-to-back blocks (din_valid held high) SHALL give a dout_valid pulse every OUT_SIZE cycles, with no lost samples.
REQ-024 Flush SHALL:
- clear lane_cnt and blk_cnt and force IDLE on the next edge;
- discard a sample presented in the same cycle;
- leave dout_i/dout_q unchanged.
REQ-025 If flush coincides with the completing sample, flush SHALL win: no dout_valid, no output update.
REQ-026 Samples SHALL pass through bit-exact; no arithmetic or width change is applied.

Reset
REQ-027 While rstn=0, the block SHALL hold:
- dout_i and dout_q all lanes 0;
- dout_valid, frame_start, frame_done and busy at 0;
- lane_cnt and blk_cnt at 0, staging lanes at 0, state IDLE.
REQ-028 Reset asserted mid-block SHALL discard the partial block; the first accepted sample after release SHALL be lane 0 of block 0.

Configuration
REQ-029 Macro S2P_BITREV_EN SHALL control lane placement.
- When defined, the k-th sample of a block SHALL be placed in lane bitrev(k) over log2(OUT_SIZE) bits.
- When undefined, the k-th sample SHALL be placed in lane k.
- Timing and all flags SHALL be identical in both builds.

Verification
REQ-030 The bench SHALL cover these directed scenarios:
- OUT_SIZE=16, macro off, 16 consecutive samples I=1..16, Q=-1..-16 -> one dout_valid the cycle after sample 16; dout_i[0]=1, dout_i[15]=16, dout_q[15]=-16; frame_start=1.
- Same samples with S2P_BITREV_EN defined -> dout_i[8]=2, dout_i[1]=9, dout_i[15]=16.
- NUM_BLK=2, 32 samples with din_valid toggling 1/0 -> exactly 2 pulses: first with frame_start=1, second with frame_done=1; outputs hold between pulses.
- 10 samples, then flush, then 16 samples I=100..115 -> a single dout_valid with dout_i[0]=100; no pulse from the partial block.
- Flush in the same cycle as the 16th sample -> no dout_valid; the next 16 samples form block 0 with frame_start=1.
- rstn low after 7 samples, then released, then 16 samples -> all outputs 0 during reset; the single following pulse carries only post-reset data.

Source files
------------

// File: rtl/s2p_packer_if.sv
// Serial-in / parallel-out packer bus: serial I/Q sample stream in, registered parallel block out.
interface s2p_packer_if #(
  parameter int unsigned DATA_WIDTH = 9,
  parameter int unsigned OUT_SIZE   = 16
);
  logic                         din_valid;
  logic signed [DATA_WIDTH-1:0] din_i;
  logic signed [DATA_WIDTH-1:0] din_q;
  logic                         flush;
  logic signed [DATA_WIDTH-1:0] dout_i [OUT_SIZE];
  logic signed [DATA_WIDTH-1:0] dout_q [OUT_SIZE];
  logic                         dout_valid;
  logic                         frame_start;
  logic                         frame_done;
  logic                         busy;

  modport master (
    output din_valid, din_i, din_q, flush,
    input  dout_i, dout_q, dout_valid, frame_start, frame_done, busy
  );

  modport slave (
    input  din_valid, din_i, din_q, flush,
    output dout_i, dout_q, dout_valid, frame_start, frame_done, busy
  );
endinterface

// File: rtl/s2p_packer.sv
// Packs OUT_SIZE serial I/Q samples into one registered parallel block and tracks blocks per frame.
// Define S2P_BITREV_EN to place the k-th sample of a block in lane bitrev(k) instead of lane k.
module s2p_packer #(
  parameter int unsigned DATA_WIDTH = 9,
  parameter int unsigned OUT_SIZE   = 16,
  parameter int unsigned NUM_BLK    = 32
) (
  input  logic       clk,
  input  logic       rstn,
  s2p_packer_if.slave bus
);
  localparam int unsigned CNT_W = $clog2(OUT_SIZE);
  localparam int unsigned BLK_W = (NUM_BLK > 1) ? $clog2(NUM_BLK) : 1;
  localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(OUT_SIZE - 1);
  localparam logic [BLK_W-1:0] LAST_BLK  = BLK_W'(NUM_BLK - 1);

  typedef enum logic {IDLE, FILL} state_t;

  state_t                       state, state_next;
  logic [CNT_W-1:0]             lane_cnt, lane_cnt_next, lane_idx;
  logic [BLK_W-1:0]             blk_cnt, blk_cnt_next;
  logic                         take, blk_done;
  logic signed [DATA_WIDTH-1:0] stage_i [OUT_SIZE];
  logic signed [DATA_WIDTH-1:0] stage_q [OUT_SIZE];

`ifdef S2P_BITREV_EN
  // Reverse the sample ordinal to get its lane
  always_comb begin
    lane_idx = '0;
    for (int b = 0; b < int'(CNT_W); b++) lane_idx[b] = lane_cnt[int'(CNT_W) - 1 - b];
  end
`else
  assign lane_idx = lane_cnt;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      lane_cnt <= '0;
      blk_cnt  <= '0;
    end else begin
      state    <= state_next;
      lane_cnt <= lane_cnt_next;
      blk_cnt  <= blk_cnt_next;
    end
  end

  // Flush outranks a sample in the same cycle, including a block-completing one
  always_comb begin
    state_next    = state;
    lane_cnt_next = lane_cnt;
    blk_cnt_next  = blk_cnt;
    take          = 1'b0;
    blk_done      = 1'b0;
    if (bus.flush) begin
      state_next    = IDLE;
      lane_cnt_next = '0;
      blk_cnt_next  = '0;
    end else if (bus.din_valid) begin
      take = 1'b1;
      case (state)
        IDLE: begin
          lane_cnt_next = CNT_W'(1);
          state_next    = FILL;
        end
        FILL: begin
          if (lane_cnt == LAST_LANE) begin
            blk_done      = 1'b1;
            lane_cnt_next = '0;
            state_next    = IDLE;
            blk_cnt_next  = (blk_cnt == LAST_BLK) ? '0 : blk_cnt + BLK_W'(1);
          end else begin
            lane_cnt_next = lane_cnt + CNT_W'(1);
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Staging lanes and output block; the completing sample bypasses staging into the output
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int l = 0; l < int'(OUT_SIZE); l++) begin
        stage_i[l]    <= '0;
        stage_q[l]    <= '0;
        bus.dout_i[l] <= '0;
        bus.dout_q[l] <= '0;
      end
      bus.dout_valid  <= 1'b0;
      bus.frame_start <= 1'b0;
      bus.frame_done  <= 1'b0;
      bus.busy        <= 1'b0;
    end else begin
      for (int l = 0; l < int'(OUT_SIZE); l++) begin
        if (take && (lane_idx == CNT_W'(l))) begin
          stage_i[l] <= bus.din_i;
          stage_q[l] <= bus.din_q;
        end
        if (blk_done) begin
          bus.dout_i[l] <= (lane_idx == CNT_W'(l)) ? bus.din_i : stage_i[l];
          bus.dout_q[l] <= (lane_idx == CNT_W'(l)) ? bus.din_q : stage_q[l];
        end
      end
      bus.dout_valid  <= blk_done;
      bus.frame_start <= blk_done && (blk_cnt == '0);
      bus.frame_done  <= blk_done && (blk_cnt == LAST_BLK);
      bus.busy        <= (state_next == FILL);
    end
  end
endmodule

// File: tb/tb_s2p_packer.sv
// Scoreboard bench for s2p_packer: two instances (NUM_BLK=32 and NUM_BLK=2) share one stimulus stream.
module tb_s2p_packer;
  localparam int DW = 9;
  localparam int OS = 16;

  typedef struct {
    logic signed [DW-1:0] i [OS];
    logic signed [DW-1:0] q [OS];
    int                   blk;
  } exp_t;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  s2p_packer_if #(.DATA_WIDTH(DW), .OUT_SIZE(OS)) bus_a ();
  s2p_packer_if #(.DATA_WIDTH(DW), .OUT_SIZE(OS)) bus_b ();

  s2p_packer #(.DATA_WIDTH(DW), .OUT_SIZE(OS), .NUM_BLK(32)) u_dut_a (.clk(clk), .rstn(rstn), .bus(bus_a));
  s2p_packer #(.DATA_WIDTH(DW), .OUT_SIZE(OS), .NUM_BLK(2))  u_dut_b (.clk(clk), .rstn(rstn), .bus(bus_b));

  assign bus_b.din_valid = bus_a.din_valid;
  assign bus_b.din_i     = bus_a.din_i;
  assign bus_b.din_q     = bus_a.din_q;
  assign bus_b.flush     = bus_a.flush;

  int n_cmp = 0;
  int n_bad = 0;
  int pulses = 0;

  exp_t sb[$];
  logic signed [DW-1:0] m_i [OS];
  logic signed [DW-1:0] m_q [OS];
  int m_k, m_blk;
  logic signed [DW-1:0] held_i [OS];
  logic signed [DW-1:0] held_q [OS];
  int held_blk;

  function automatic void chk(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic int lane_of(int k);
`ifdef S2P_BITREV_EN
    return int'({k[0], k[1], k[2], k[3]});
`else
    return k;
`endif
  endfunction

  function automatic void model_clear();
    sb.delete();
    m_k = 0;
    m_blk = 0;
    for (int l = 0; l < OS; l++) begin
      held_i[l] = '0;
      held_q[l] = '0;
    end
  endfunction

  // One clock of stimulus; the model is advanced after the edge that accepts the sample
  task automatic step(input bit v, input int di, input int dq, input bit fl);
    exp_t e;
    bus_a.din_valid = v;
    bus_a.din_i     = DW'(di);
    bus_a.din_q     = DW'(dq);
    bus_a.flush     = fl;
    @(posedge clk);
    if (fl) begin
      m_k = 0;
      m_blk = 0;
    end else if (v) begin
      m_i[lane_of(m_k)] = DW'(di);
      m_q[lane_of(m_k)] = DW'(dq);
      if (m_k == OS - 1) begin
        e.i = m_i;
        e.q = m_q;
        e.blk = m_blk;
        sb.push_back(e);
        m_blk++;
        m_k = 0;
      end else begin
        m_k++;
      end
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) step(1'b0, 0, 0, 1'b0);
  endtask

  task automatic samples(input int n, input int bi, input int bq, input int gap);
    for (int k = 0; k < n; k++) begin
      step(1'b1, bi + k, bq - k, 1'b0);
      idle(gap);
    end
  endtask

  // Monitor: pops one expectation per dout_valid and checks held outputs every cycle
  int la, lb;
  bit have;
  exp_t e_mon;
  always @(negedge clk) begin
    have = (sb.size() > 0);
    if (have) begin
      e_mon = sb.pop_front();
      held_i = e_mon.i;
      held_q = e_mon.q;
      held_blk = e_mon.blk;
    end
    chk("dout_valid_a", int'(bus_a.dout_valid), int'(have));
    chk("dout_valid_b", int'(bus_b.dout_valid), int'(have));
    chk("frame_start_a", int'(bus_a.frame_start), int'(have && (held_blk % 32 == 0)));
    chk("frame_done_a",  int'(bus_a.frame_done),  int'(have && (held_blk % 32 == 31)));
    chk("frame_start_b", int'(bus_b.frame_start), int'(have && (held_blk % 2 == 0)));
    chk("frame_done_b",  int'(bus_b.frame_done),  int'(have && (held_blk % 2 == 1)));
    chk("busy_a", int'(bus_a.busy), int'(m_k != 0));
    chk("busy_b", int'(bus_b.busy), int'(m_k != 0));
    la = 0;
    lb = 0;
    for (int l = OS - 1; l >= 0; l--) begin
      if (bus_a.dout_i[l] !== held_i[l] || bus_a.dout_q[l] !== held_q[l]) la = l;
      if (bus_b.dout_i[l] !== held_i[l] || bus_b.dout_q[l] !== held_q[l]) lb = l;
    end
    chk("dout_i_a", int'(bus_a.dout_i[la]), int'(held_i[la]));
    chk("dout_q_a", int'(bus_a.dout_q[la]), int'(held_q[la]));
    chk("dout_i_b", int'(bus_b.dout_i[lb]), int'(held_i[lb]));
    chk("dout_q_b", int'(bus_b.dout_q[lb]), int'(held_q[lb]));
    if (bus_a.dout_valid) pulses++;
  end

  int p0;
  initial begin
    rstn = 1'b1;
    bus_a.din_valid = 1'b0;
    bus_a.din_i = '0;
    bus_a.din_q = '0;
    bus_a.flush = 1'b0;
    model_clear();
    #2 rstn = 1'b0;
    idle(3);
    rstn = 1'b1;
    idle(2);

    // 16 consecutive samples, I=1..16, Q=-1..-16
    p0 = pulses;
    samples(16, 1, -1, 0);
    idle(2);
    chk("s1_pulses", pulses - p0, 1);
    chk("s1_dout_i0", int'(bus_a.dout_i[0]), 1);
    chk("s1_dout_i15", int'(bus_a.dout_i[15]), 16);
`ifdef S2P_BITREV_EN
    chk("s1_dout_i8", int'(bus_a.dout_i[8]), 2);
    chk("s1_dout_i1", int'(bus_a.dout_i[1]), 9);
`else
    chk("s1_dout_q15", int'(bus_a.dout_q[15]), -16);
    chk("s1_dout_i1", int'(bus_a.dout_i[1]), 2);
`endif

    // Two blocks with din_valid toggling, starting from a fresh frame
    step(1'b0, 0, 0, 1'b1);
    p0 = pulses;
    samples(16, 20, -40, 1);
    samples(16, 36, -56, 1);
    idle(2);
    chk("s3_pulses", pulses - p0, 2);
    chk("s3_dout_i0", int'(bus_a.dout_i[0]), 36);

    // Partial block discarded by flush
    p0 = pulses;
    samples(10, 200, -200, 0);
    step(1'b0, 0, 0, 1'b1);
    samples(16, 100, -100, 0);
    idle(2);
    chk("s4_pulses", pulses - p0, 1);
    chk("s4_dout_i0", int'(bus_a.dout_i[0]), 100);

    // Flush coinciding with the completing sample
    p0 = pulses;
    samples(15, 50, -50, 0);
    step(1'b1, 65, -65, 1'b1);
    idle(2);
    chk("s5_no_pulse", pulses - p0, 0);
    chk("s5_held_i0", int'(bus_a.dout_i[0]), 100);
    samples(16, -128, 127, 0);
    idle(2);
    chk("s5_pulses", pulses - p0, 1);
    chk("s5_dout_i15", int'(bus_a.dout_i[15]), -113);

    // Reset in the middle of a block
    p0 = pulses;
    samples(7, 77, 77, 0);
    rstn = 1'b0;
    model_clear();
    idle(3);
    chk("s6_rst_dout_i15", int'(bus_a.dout_i[15]), 0);
    rstn = 1'b1;
    idle(1);
    samples(16, -50, 60, 0);
    idle(2);
    chk("s6_pulses", pulses - p0, 1);
    chk("s6_dout_i0", int'(bus_a.dout_i[0]), -50);
    chk("s6_dout_q15", int'(bus_a.dout_q[15]), 45);

    // Back-to-back blocks continue the frame count
    p0 = pulses;
    samples(32, -256, 255, 0);
    idle(2);
    chk("s7_pulses", pulses - p0, 2);
    chk("s7_queue_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
